// File: rtl/writeback_queue.sv
// Merges execute and load writeback results into one in-order FIFO and drains one regfile write per cycle.
// Latency: a result accepted at edge N is on the write port during cycle N+1 when the FIFO was empty.
// Backpressure: the drain never stalls. Load takes priority for a free slot, and execute needs a second slot when a load pushes.
// Optional feature: WB_QUEUE_BYPASS_EN enables forwarding of the youngest queued data per source register.
module writeback_queue #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid_i,
    output logic                         ex_ready_o,
    input  logic [4:0]                   ex_rd_i,
    input  logic [DWIDTH-1:0]            ex_data_i,
    input  logic                         ld_valid_i,
    output logic                         ld_ready_o,
    input  logic [4:0]                   ld_rd_i,
    input  logic [DWIDTH-1:0]            ld_data_i,
    output logic [4:0]                   rd_o,
    output logic [DWIDTH-1:0]            datawb_o,
    output logic                         regwren_o,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    output logic                         rs1_pending_o,
    output logic                         rs2_pending_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         rs1_fwd_valid_o,
    output logic [DWIDTH-1:0]            rs1_fwd_data_o,
    output logic                         rs2_fwd_valid_o,
    output logic [DWIDTH-1:0]            rs2_fwd_data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DWIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic            pop;
    logic            ld_need;
    logic            ld_push;
    logic            ex_push;
    logic            rs1_hit;
    logic            rs2_hit;

    // The head always retires this cycle, so its slot is reusable by a push at the same edge.
    assign pop     = (count != '0);
    assign free    = CW'(DEPTH) - count + CW'(pop);
    assign ld_need = ld_valid_i && (ld_rd_i != 5'd0);

    assign ld_ready_o = (free >= CW'(1));
    assign ex_ready_o = ld_need ? (free >= CW'(2)) : (free >= CW'(1));

    assign ld_push = ld_valid_i && ld_ready_o && (ld_rd_i != 5'd0);
    assign ex_push = ex_valid_i && ex_ready_o && (ex_rd_i != 5'd0);

    always_ff @(posedge clk) begin
        if (rst && ld_push)
            mem[tail] <= '{rd: ld_rd_i, data: ld_data_i};
        if (rst && ex_push)
            mem[tail + PW'(ld_push)] <= '{rd: ex_rd_i, data: ex_data_i};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(ld_push) + PW'(ex_push);
            count <= count + CW'(ld_push) + CW'(ex_push) - CW'(pop);
        end
    end

    assign count_o   = count;
    assign regwren_o = pop;
    assign rd_o      = pop ? mem[head].rd   : 5'd0;
    assign datawb_o  = pop ? mem[head].data : '0;

    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (mem[idx].rd == rs1_i) rs1_hit = 1'b1;
                if (mem[idx].rd == rs2_i) rs2_hit = 1'b1;
            end
        end
    end

    assign rs1_pending_o = (rs1_i != 5'd0) && rs1_hit;
    assign rs2_pending_o = (rs2_i != 5'd0) && rs2_hit;

`ifdef WB_QUEUE_BYPASS_EN
    logic [DWIDTH-1:0] rs1_young;
    logic [DWIDTH-1:0] rs2_young;

    // Scanning oldest to youngest lets the last match win.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        rs1_young = '0;
        rs2_young = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (mem[idx].rd == rs1_i) rs1_young = mem[idx].data;
                if (mem[idx].rd == rs2_i) rs2_young = mem[idx].data;
            end
        end
    end

    assign rs1_fwd_valid_o = rs1_pending_o;
    assign rs2_fwd_valid_o = rs2_pending_o;
    assign rs1_fwd_data_o  = rs1_pending_o ? rs1_young : '0;
    assign rs2_fwd_data_o  = rs2_pending_o ? rs2_young : '0;
`else
    assign rs1_fwd_valid_o = 1'b0;
    assign rs2_fwd_valid_o = 1'b0;
    assign rs1_fwd_data_o  = '0;
    assign rs2_fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue-based model.
module tb_writeback_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid_i, ld_valid_i;
    logic          ex_ready_o, ld_ready_o;
    logic [4:0]    ex_rd_i, ld_rd_i, rs1_i, rs2_i, rd_o;
    logic [DW-1:0] ex_data_i, ld_data_i, datawb_o;
    logic          regwren_o, rs1_pending_o, rs2_pending_o;
    logic [2:0]    count_o;
    logic          rs1_fwd_valid_o, rs2_fwd_valid_o;
    logic [DW-1:0] rs1_fwd_data_o, rs2_fwd_data_o;

    writeback_queue #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
        .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1_pending_o(rs1_pending_o), .rs2_pending_o(rs2_pending_o), .count_o(count_o),
        .rs1_fwd_valid_o(rs1_fwd_valid_o), .rs1_fwd_data_o(rs1_fwd_data_o),
        .rs2_fwd_valid_o(rs2_fwd_valid_o), .rs2_fwd_data_o(rs2_fwd_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   model_ok = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected pending flag and youngest data for one source register.
    task automatic lookup(input logic [4:0] rs, output logic hit, output logic [DW-1:0] young);
        hit   = 1'b0;
        young = '0;
        if (rs != 5'd0)
            foreach (q[i])
                if (q[i].rd == rs) begin
                    hit   = 1'b1;
                    young = q[i].data;
                end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model, return at posedge+1.
    task automatic step(input logic r,
                        input logic lv, input logic [4:0] lr, input logic [DW-1:0] ldat,
                        input logic ev, input logic [4:0] er, input logic [DW-1:0] edat,
                        input logic [4:0] s1, input logic [4:0] s2);
        int            free;
        logic          exp_lr, exp_er, p1, p2;
        logic [DW-1:0] f1, f2;
        ent_t          e;
        exp_lr = 1'b0;
        exp_er = 1'b0;
        @(negedge clk);
        rst = r;
        ld_valid_i = lv; ld_rd_i = lr; ld_data_i = ldat;
        ex_valid_i = ev; ex_rd_i = er; ex_data_i = edat;
        rs1_i = s1; rs2_i = s2;
        #1;
        if (model_ok) begin
            free   = DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
            exp_lr = (free >= 1);
            exp_er = (lv && lr != 5'd0) ? (free >= 2) : (free >= 1);
            chk("ld_ready", 64'(ld_ready_o), 64'(exp_lr));
            chk("ex_ready", 64'(ex_ready_o), 64'(exp_er));
            chk("regwren", 64'(regwren_o), 64'(q.size() != 0));
            chk("rd", 64'(rd_o), (q.size() != 0) ? 64'(q[0].rd) : 64'd0);
            chk("datawb", 64'(datawb_o), (q.size() != 0) ? 64'(q[0].data) : 64'd0);
            chk("count", 64'(count_o), 64'(q.size()));
            chk("count_max", 64'(count_o > 3'(DEPTH)), 64'd0);
            lookup(s1, p1, f1);
            lookup(s2, p2, f2);
            chk("rs1_pending", 64'(rs1_pending_o), 64'(p1));
            chk("rs2_pending", 64'(rs2_pending_o), 64'(p2));
`ifdef WB_QUEUE_BYPASS_EN
            chk("rs1_fwd_valid", 64'(rs1_fwd_valid_o), 64'(p1));
            chk("rs1_fwd_data", 64'(rs1_fwd_data_o), 64'(f1));
            chk("rs2_fwd_valid", 64'(rs2_fwd_valid_o), 64'(p2));
            chk("rs2_fwd_data", 64'(rs2_fwd_data_o), 64'(f2));
`else
            chk("rs1_fwd_valid", 64'(rs1_fwd_valid_o), 64'd0);
            chk("rs1_fwd_data", 64'(rs1_fwd_data_o), 64'd0);
            chk("rs2_fwd_valid", 64'(rs2_fwd_valid_o), 64'd0);
            chk("rs2_fwd_data", 64'(rs2_fwd_data_o), 64'd0);
`endif
        end
        if (!r) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (q.size() != 0) void'(q.pop_front());
            if (lv && exp_lr && lr != 5'd0) begin e.rd = lr; e.data = ldat; q.push_back(e); end
            if (ev && exp_er && er != 5'd0) begin e.rd = er; e.data = edat; q.push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
        step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, s1, s2);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid_i = 1'b0; ld_valid_i = 1'b0;
        ex_rd_i = '0; ld_rd_i = '0; ex_data_i = '0; ld_data_i = '0;
        rs1_i = '0; rs2_i = '0;

        // Reset held two cycles while execute is requesting
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h55, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h55, 5'd0, 5'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_regwren", 64'(regwren_o), 64'd0);
        idle(5'd0, 5'd0);
        chk("rst_ex_ready", 64'(ex_ready_o), 64'd1);
        chk("rst_no_write", 64'(regwren_o), 64'd0);

        // Single execute result
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd5, 32'h1234, 5'd0, 5'd0);
        chk("single_wren", 64'(regwren_o), 64'd1);
        chk("single_rd", 64'(rd_o), 64'd5);
        chk("single_data", 64'(datawb_o), 64'h1234);
        idle(5'd0, 5'd0);
        chk("single_done", 64'(regwren_o), 64'd0);

        // Dual accept, load drains first
        step(1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB, 5'd0, 5'd0);
        chk("dual_rd0", 64'(rd_o), 64'd3);
        chk("dual_data0", 64'(datawb_o), 64'hAA);
        idle(5'd0, 5'd0);
        chk("dual_rd1", 64'(rd_o), 64'd4);
        chk("dual_data1", 64'(datawb_o), 64'hBB);
        idle(5'd0, 5'd0);
        chk("dual_done", 64'(regwren_o), 64'd0);

        // Fill to DEPTH, then both sources request while full
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 5'(10 + 2*i), 32'(100 + i), 1'b1, 5'(11 + 2*i), 32'(200 + i), 5'd0, 5'd0);
        chk("full_count", 64'(count_o), 64'd4);
        step(1'b1, 1'b1, 5'd20, 32'h300, 1'b1, 5'd21, 32'h400, 5'd0, 5'd0);
        chk("full_ld_ready", 64'(ld_ready_o), 64'd1);
        chk("full_ex_ready", 64'(ex_ready_o), 64'd0);
        chk("full_count2", 64'(count_o), 64'd4);
        for (int i = 0; i < 5; i++) idle(5'd0, 5'd0);

        // rd==0 requests complete but are dropped
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        chk("rd0_ex_ready", 64'(ex_ready_o), 64'd1);
        chk("rd0_count", 64'(count_o), 64'd0);
        chk("rd0_no_write", 64'(regwren_o), 64'd0);

        // Two queued writes to r7; youngest wins forwarding
        step(1'b1, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 5'd7, 5'd0);
        chk("pend_rs1", 64'(rs1_pending_o), 64'd1);
        chk("pend_rs2", 64'(rs2_pending_o), 64'd0);
`ifdef WB_QUEUE_BYPASS_EN
        chk("pend_fwd", 64'(rs1_fwd_data_o), 64'd2);
`else
        chk("pend_fwd", 64'(rs1_fwd_data_o), 64'd0);
`endif
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);
        chk("pend_clear", 64'(rs1_pending_o), 64'd0);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 4) < 3), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
